// File: rtl/dram_refresh_arbiter.sv
// FastRAM DRAM sequencer: arbitrates CPU accesses against CAS-before-RAS refresh
// and drives RAS/CAS/WE plus the row/column mux select from registered outputs.
module dram_refresh_arbiter #(
  parameter int unsigned REFRESH_INTERVAL = 110,
  parameter int unsigned MAX_PENDING      = 4,
  parameter int unsigned T_RCD            = 1,
  parameter int unsigned T_RAS_REF        = 2,
  parameter int unsigned T_RP             = 2
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic                             cpu_req,
  input  logic                             cpu_rwn,
  input  logic                             cpu_ube,
  input  logic                             cpu_lbe,
  output logic                             cpu_ack,
  output logic                             RASn,
  output logic                             UCASn,
  output logic                             LCASn,
  output logic                             MEMWn,
  output logic                             row_sel,
  output logic                             refresh_busy,
  output logic [$clog2(MAX_PENDING+1)-1:0] pending_count,
  output logic                             refresh_overrun
);

  localparam int unsigned CntW   = $clog2(MAX_PENDING + 1);
  localparam int unsigned TimerW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam int unsigned MaxT   = (T_RCD > T_RAS_REF) ? ((T_RCD > T_RP) ? T_RCD : T_RP)
                                                       : ((T_RAS_REF > T_RP) ? T_RAS_REF : T_RP);
  localparam int unsigned PhaseW = $clog2(MaxT + 1);

  localparam logic [TimerW-1:0] TimerReload = TimerW'(REFRESH_INTERVAL - 1);
  localparam logic [CntW-1:0]   PendMax     = CntW'(MAX_PENDING);
  localparam logic [PhaseW-1:0] RcdLoad     = PhaseW'(T_RCD - 1);
  localparam logic [PhaseW-1:0] RasRefLoad  = PhaseW'(T_RAS_REF - 1);
  localparam logic [PhaseW-1:0] RpLoad      = PhaseW'(T_RP - 1);

  typedef enum logic [2:0] {
    StIdle,
    StAccRas,
    StAccCas,
    StRefCas,
    StRefRas,
    StPrecharge
  } state_e;

  state_e              state_q, state_d;
  logic [PhaseW-1:0]   phase_q, phase_d;
  logic [TimerW-1:0]   timer_q;
  logic                tick;
  logic                ref_start;
  logic                ack_d, ras_n_d, ucas_n_d, lcas_n_d, memw_n_d, row_sel_d, busy_d;
  logic [CntW-1:0]     pending_d;
  logic                overrun_d;

  assign tick      = (timer_q == '0);
  assign ref_start = (state_q == StIdle) && (state_d == StRefCas);

  // Phase counter holds remaining clocks minus one; reloaded on every timed state entry.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    unique case (state_q)
      StIdle: begin
        if (pending_count == PendMax) begin
          state_d = StRefCas;
        end else if (cpu_req) begin
          state_d = StAccRas;
          phase_d = RcdLoad;
        end else if (pending_count != '0) begin
          state_d = StRefCas;
        end
      end
      StAccRas: begin
        if (!cpu_req) begin
          state_d = StPrecharge;
          phase_d = RpLoad;
        end else if (phase_q == '0) begin
          state_d = StAccCas;
        end else begin
          phase_d = phase_q - PhaseW'(1);
        end
      end
      StAccCas: begin
        if (!cpu_req) begin
          state_d = StPrecharge;
          phase_d = RpLoad;
        end
      end
      StRefCas: begin
        state_d = StRefRas;
        phase_d = RasRefLoad;
      end
      StRefRas: begin
        if (phase_q == '0) begin
          state_d = StPrecharge;
          phase_d = RpLoad;
        end else begin
          phase_d = phase_q - PhaseW'(1);
        end
      end
      StPrecharge: begin
        if (phase_q == '0) begin
          state_d = StIdle;
        end else begin
          phase_d = phase_q - PhaseW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobes are decoded from the next state so each pin changes on the transition edge.
  always_comb begin
    ack_d     = 1'b0;
    ras_n_d   = 1'b1;
    ucas_n_d  = 1'b1;
    lcas_n_d  = 1'b1;
    memw_n_d  = 1'b1;
    row_sel_d = 1'b1;
    busy_d    = 1'b0;
    unique case (state_d)
      StAccRas: ras_n_d = 1'b0;
      StAccCas: begin
        ras_n_d   = 1'b0;
        row_sel_d = 1'b0;
        ack_d     = 1'b1;
        ucas_n_d  = ~cpu_ube;
        lcas_n_d  = ~cpu_lbe;
        memw_n_d  = cpu_rwn;
      end
      StRefCas: begin
        ucas_n_d = 1'b0;
        lcas_n_d = 1'b0;
        busy_d   = 1'b1;
      end
      StRefRas: begin
        ras_n_d  = 1'b0;
        ucas_n_d = 1'b0;
        lcas_n_d = 1'b0;
        busy_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // A tick and a refresh start on the same edge cancel; a tick into a full queue is lost.
  always_comb begin
    pending_d = pending_count;
    overrun_d = refresh_overrun;
    if (tick && !ref_start) begin
      if (pending_count == PendMax) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = pending_count + CntW'(1);
      end
    end else if (!tick && ref_start) begin
      pending_d = pending_count - CntW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q         <= StIdle;
      phase_q         <= '0;
      timer_q         <= TimerReload;
      pending_count   <= '0;
      refresh_overrun <= 1'b0;
      cpu_ack         <= 1'b0;
      RASn            <= 1'b1;
      UCASn           <= 1'b1;
      LCASn           <= 1'b1;
      MEMWn           <= 1'b1;
      row_sel         <= 1'b1;
      refresh_busy    <= 1'b0;
    end else begin
      state_q         <= state_d;
      phase_q         <= phase_d;
      timer_q         <= tick ? TimerReload : timer_q - TimerW'(1);
      pending_count   <= pending_d;
      refresh_overrun <= overrun_d;
      cpu_ack         <= ack_d;
      RASn            <= ras_n_d;
      UCASn           <= ucas_n_d;
      LCASn           <= lcas_n_d;
      MEMWn           <= memw_n_d;
      row_sel         <= row_sel_d;
      refresh_busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_dram_refresh_arbiter.sv
// Bench for dram_refresh_arbiter: directed scenarios plus random traffic, all checked
// against a timeline-queue reference model of the sequencer.
module tb_dram_refresh_arbiter;

  localparam int RI   = 110;
  localparam int MP   = 4;
  localparam int TRCD = 1;
  localparam int TRAS = 2;
  localparam int TRP  = 2;

  localparam int PhAras = 1;
  localparam int PhAcas = 2;
  localparam int PhRcas = 3;
  localparam int PhRras = 4;
  localparam int PhPre  = 5;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       cpu_req = 1'b0;
  logic       cpu_rwn = 1'b1;
  logic       cpu_ube = 1'b0;
  logic       cpu_lbe = 1'b0;
  logic       cpu_ack, RASn, UCASn, LCASn, MEMWn, row_sel, refresh_busy, refresh_overrun;
  logic [2:0] pending_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of upcoming phases, front = phase the DUT should be in now.
  int          q[$];
  int          pend = 0;
  bit          ovr = 1'b0;
  int          since = 0;
  logic [10:0] exp_v;

  always #5 CLK = ~CLK;

  dram_refresh_arbiter #(
    .REFRESH_INTERVAL(RI),
    .MAX_PENDING     (MP),
    .T_RCD           (TRCD),
    .T_RAS_REF       (TRAS),
    .T_RP            (TRP)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .cpu_req        (cpu_req),
    .cpu_rwn        (cpu_rwn),
    .cpu_ube        (cpu_ube),
    .cpu_lbe        (cpu_lbe),
    .cpu_ack        (cpu_ack),
    .RASn           (RASn),
    .UCASn          (UCASn),
    .LCASn          (LCASn),
    .MEMWn          (MEMWn),
    .row_sel        (row_sel),
    .refresh_busy   (refresh_busy),
    .pending_count  (pending_count),
    .refresh_overrun(refresh_overrun)
  );

  function automatic logic [10:0] obs_vec();
    return {cpu_ack, RASn, UCASn, LCASn, MEMWn, row_sel, refresh_busy, pending_count,
            refresh_overrun};
  endfunction

  function automatic void model_edge();
    bit   tick;
    bit   rs;
    int   ph;
    logic a, r, u, l, w, rw, b;
    tick = 1'b0;
    rs   = 1'b0;
    if (RESET) begin
      q.delete();
      pend  = 0;
      ovr   = 1'b0;
      since = 0;
    end else begin
      since++;
      tick = (since % RI) == 0;
      if (q.size() == 0) begin
        if (pend == MP || (!cpu_req && pend > 0)) begin
          rs = 1'b1;
          q.push_back(PhRcas);
          for (int k = 0; k < TRAS; k++) q.push_back(PhRras);
          for (int k = 0; k < TRP; k++) q.push_back(PhPre);
        end else if (cpu_req) begin
          for (int k = 0; k < TRCD; k++) q.push_back(PhAras);
          q.push_back(PhAcas);
        end
      end else if ((q[0] == PhAras || q[0] == PhAcas) && !cpu_req) begin
        q.delete();
        for (int k = 0; k < TRP; k++) q.push_back(PhPre);
      end else if (q[0] != PhAcas) begin
        void'(q.pop_front());
      end
      if (tick && !rs) begin
        if (pend == MP) ovr = 1'b1;
        else pend++;
      end else if (!tick && rs) begin
        pend--;
      end
    end
    ph = (q.size() == 0) ? 0 : q[0];
    a = 1'b0; r = 1'b1; u = 1'b1; l = 1'b1; w = 1'b1; rw = 1'b1; b = 1'b0;
    case (ph)
      PhAras: r = 1'b0;
      PhAcas: begin r = 1'b0; rw = 1'b0; a = 1'b1; u = ~cpu_ube; l = ~cpu_lbe; w = cpu_rwn; end
      PhRcas: begin u = 1'b0; l = 1'b0; b = 1'b1; end
      PhRras: begin r = 1'b0; u = 1'b0; l = 1'b0; b = 1'b1; end
      default: ;
    endcase
    exp_v = {a, r, u, l, w, rw, b, 3'(pend), ovr};
  endfunction

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    cpu_req = 1'b0;
    step();
    step();
    n_checks++;
    if (obs_vec() !== {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_state got=%b exp=%b", obs_vec(),
               {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0});
    end
  endtask

  task automatic test_refresh_idle();
    RESET = 1'b0;
    for (int i = 1; i <= RI; i++) begin
      step();
      n_checks++;
      if (obs_vec() !== exp_v) begin
        n_errors++;
        $display("FAIL refresh_idle_wait edge=%0d got=%b exp=%b", i, obs_vec(), exp_v);
      end
    end
    n_checks++;
    if (pending_count !== 3'd1 || refresh_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL first_tick pending=%0d busy=%b exp pending=1 busy=0", pending_count,
               refresh_busy);
    end
    step();
    n_checks++;
    if ({RASn, UCASn, LCASn, MEMWn, refresh_busy, pending_count} !== {4'b1001, 1'b1, 3'd0}) begin
      n_errors++;
      $display("FAIL ref_cas got RAS/UCAS/LCAS/MEMW=%b%b%b%b busy=%b pend=%0d exp 1001 1 0",
               RASn, UCASn, LCASn, MEMWn, refresh_busy, pending_count);
    end
    for (int i = 0; i < TRAS + TRP + 1; i++) begin
      step();
      n_checks++;
      if (obs_vec() !== exp_v || MEMWn !== 1'b1) begin
        n_errors++;
        $display("FAIL refresh_seq step=%0d got=%b exp=%b", i, obs_vec(), exp_v);
      end
    end
  endtask

  task automatic test_word_read();
    cpu_req = 1'b1; cpu_rwn = 1'b1; cpu_ube = 1'b1; cpu_lbe = 1'b1;
    step();
    n_checks++;
    if ({RASn, row_sel, cpu_ack, UCASn, LCASn} !== 5'b01011) begin
      n_errors++;
      $display("FAIL read_ras got RAS/row/ack/UCAS/LCAS=%b%b%b%b%b exp 01011",
               RASn, row_sel, cpu_ack, UCASn, LCASn);
    end
    step();
    n_checks++;
    if ({RASn, row_sel, cpu_ack, UCASn, LCASn, MEMWn} !== 6'b001001) begin
      n_errors++;
      $display("FAIL read_cas got RAS/row/ack/UCAS/LCAS/MEMW=%b%b%b%b%b%b exp 001001",
               RASn, row_sel, cpu_ack, UCASn, LCASn, MEMWn);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (obs_vec() !== exp_v) begin
        n_errors++;
        $display("FAIL read_hold step=%0d got=%b exp=%b", i, obs_vec(), exp_v);
      end
    end
    cpu_req = 1'b0;
    step();
    n_checks++;
    if ({cpu_ack, RASn, UCASn, LCASn, MEMWn, row_sel} !== 6'b011111) begin
      n_errors++;
      $display("FAIL read_release got ack/RAS/UCAS/LCAS/MEMW/row=%b exp 011111",
               {cpu_ack, RASn, UCASn, LCASn, MEMWn, row_sel});
    end
    for (int i = 0; i < TRP + 1; i++) begin
      step();
      n_checks++;
      if (obs_vec() !== exp_v) begin
        n_errors++;
        $display("FAIL read_precharge step=%0d got=%b exp=%b", i, obs_vec(), exp_v);
      end
    end
  endtask

  task automatic test_byte_write();
    cpu_req = 1'b1; cpu_rwn = 1'b0; cpu_ube = 1'b0; cpu_lbe = 1'b1;
    step();
    step();
    n_checks++;
    if ({UCASn, LCASn, MEMWn, cpu_ack} !== 4'b1001) begin
      n_errors++;
      $display("FAIL byte_write got UCAS/LCAS/MEMW/ack=%b exp 1001",
               {UCASn, LCASn, MEMWn, cpu_ack});
    end
    step();
    n_checks++;
    if (obs_vec() !== exp_v) begin
      n_errors++;
      $display("FAIL byte_write_hold got=%b exp=%b", obs_vec(), exp_v);
    end
    cpu_req = 1'b0;
    step();
    n_checks++;
    if ({MEMWn, UCASn, LCASn, cpu_ack} !== 4'b1110) begin
      n_errors++;
      $display("FAIL byte_write_release got MEMW/UCAS/LCAS/ack=%b exp 1110",
               {MEMWn, UCASn, LCASn, cpu_ack});
    end
    for (int i = 0; i < TRP + 1; i++) step();
    cpu_rwn = 1'b1;
  endtask

  task automatic test_tick_collisions();
    int k;
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    cpu_req = 1'b1; cpu_rwn = 1'b1; cpu_ube = 1'b1; cpu_lbe = 1'b1;
    for (int i = 0; i < 400 && since < 2 * RI - 4; i++) begin
      step();
      n_checks++;
      if (obs_vec() !== exp_v) begin
        n_errors++;
        $display("FAIL collide_hold edge=%0d got=%b exp=%b", since, obs_vec(), exp_v);
      end
    end
    cpu_req = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if ({refresh_busy, UCASn, pending_count} !== {1'b1, 1'b0, 3'd1}) begin
      n_errors++;
      $display("FAIL tick_on_ref_entry got busy=%b UCAS=%b pend=%0d exp busy=1 UCAS=0 pend=1",
               refresh_busy, UCASn, pending_count);
    end
    for (int i = 0; i < 400 && since < 3 * RI - 1; i++) begin
      step();
      n_checks++;
      if (obs_vec() !== exp_v) begin
        n_errors++;
        $display("FAIL collide_idle edge=%0d got=%b exp=%b", since, obs_vec(), exp_v);
      end
    end
    cpu_req = 1'b1;
    step();
    n_checks++;
    if ({RASn, refresh_busy, pending_count} !== {1'b0, 1'b0, 3'd1}) begin
      n_errors++;
      $display("FAIL tick_on_cpu_start got RAS=%b busy=%b pend=%0d exp RAS=0 busy=0 pend=1",
               RASn, refresh_busy, pending_count);
    end
    for (int i = 0; i < 3; i++) step();
    cpu_req = 1'b0;
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      step();
      n_checks++;
      if (obs_vec() !== exp_v) begin
        n_errors++;
        $display("FAIL collide_after edge=%0d got=%b exp=%b", since, obs_vec(), exp_v);
      end
      if (refresh_busy === 1'b1) k = i;
    end
    n_checks++;
    if (k !== TRP + 2) begin
      n_errors++;
      $display("FAIL refresh_after_access got delay=%0d exp %0d", k, TRP + 2);
    end
  endtask

  task automatic test_priority();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    cpu_req = 1'b1; cpu_rwn = 1'b1; cpu_ube = 1'b1; cpu_lbe = 1'b1;
    for (int i = 0; i < 600 && since < 4 * RI + 5; i++) begin
      step();
      n_checks++;
      if (obs_vec() !== exp_v) begin
        n_errors++;
        $display("FAIL prio_hold edge=%0d got=%b exp=%b", since, obs_vec(), exp_v);
      end
    end
    n_checks++;
    if ({pending_count, cpu_ack, refresh_overrun} !== {3'd4, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL prio_full got pend=%0d ack=%b ovr=%b exp pend=4 ack=1 ovr=0",
               pending_count, cpu_ack, refresh_overrun);
    end
    cpu_req = 1'b0;
    step();
    cpu_req = 1'b1;
    for (int i = 0; i < TRP + 1; i++) step();
    n_checks++;
    if ({refresh_busy, UCASn, cpu_ack, pending_count} !== {1'b1, 1'b0, 1'b0, 3'd3}) begin
      n_errors++;
      $display("FAIL prio_ref_first got busy=%b UCAS=%b ack=%b pend=%0d exp 1 0 0 3",
               refresh_busy, UCASn, cpu_ack, pending_count);
    end
    for (int i = 0; i < TRAS + TRP + 1; i++) begin
      step();
      n_checks++;
      if (obs_vec() !== exp_v) begin
        n_errors++;
        $display("FAIL prio_ref_seq step=%0d got=%b exp=%b", i, obs_vec(), exp_v);
      end
    end
    step();
    n_checks++;
    if ({RASn, refresh_busy, pending_count} !== {1'b0, 1'b0, 3'd3}) begin
      n_errors++;
      $display("FAIL prio_cpu_after got RAS=%b busy=%b pend=%0d exp RAS=0 busy=0 pend=3",
               RASn, refresh_busy, pending_count);
    end
    step();
    n_checks++;
    if (cpu_ack !== 1'b1) begin
      n_errors++;
      $display("FAIL prio_cpu_ack got ack=%b exp 1", cpu_ack);
    end
  endtask

  task automatic test_overrun_reset();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    cpu_req = 1'b1;
    for (int i = 0; i < 700 && since < 5 * RI + 10; i++) begin
      step();
      n_checks++;
      if (obs_vec() !== exp_v) begin
        n_errors++;
        $display("FAIL overrun_hold edge=%0d got=%b exp=%b", since, obs_vec(), exp_v);
      end
    end
    n_checks++;
    if ({pending_count, refresh_overrun, cpu_ack} !== {3'd4, 1'b1, 1'b1}) begin
      n_errors++;
      $display("FAIL overrun got pend=%0d ovr=%b ack=%b exp pend=4 ovr=1 ack=1",
               pending_count, refresh_overrun, cpu_ack);
    end
    RESET = 1'b1;
    step();
    n_checks++;
    if (obs_vec() !== {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_mid_access got=%b exp=%b", obs_vec(),
               {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0});
    end
    RESET = 1'b0;
    cpu_req = 1'b0;
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (!cpu_req) begin
        if ($urandom_range(3) == 0) begin
          cpu_req = 1'b1;
          cpu_rwn = 1'($urandom_range(1));
          cpu_ube = 1'($urandom_range(1));
          cpu_lbe = 1'($urandom_range(1));
          hold = ($urandom_range(9) == 0) ? $urandom_range(600, 300) : $urandom_range(6, 1);
        end
      end else if (q.size() > 0 && q[0] == PhAcas) begin
        hold--;
        if (hold <= 0) cpu_req = 1'b0;
      end else if (q.size() > 0 && q[0] == PhAras && $urandom_range(49) == 0) begin
        cpu_req = 1'b0;
      end
      RESET = ($urandom_range(999) == 0);
      step();
      n_checks++;
      if (obs_vec() !== exp_v) begin
        n_errors++;
        $display("FAIL random cyc=%0d got=%b exp=%b", i, obs_vec(), exp_v);
      end
    end
    RESET = 1'b0;
  endtask

  initial begin
    test_reset();
    test_refresh_idle();
    test_word_read();
    test_byte_write();
    test_tick_collisions();
    test_priority();
    test_overrun_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dram_refresh_arbiter.md
Name: dram_refresh_arbiter

Overview:
Synchronous DRAM sequencer that shares the FastRAM array between CPU accesses and CAS-before-RAS refresh. A programmable interval timer queues refresh requests, and an arbiter schedules them around CPU cycles. Every strobe is generated cycle-exactly from one clock. Sits between the address-decode/autoconfig logic (which raises cpu_req) and the DRAM RAS/CAS/WE pins and the row/column mux select.

Parameters:
REFRESH_INTERVAL, 110, clocks between refresh requests (15.6 us at 7.09 MHz)
MAX_PENDING, 4, max queued refreshes; at this depth refresh preempts CPU
T_RCD, 1, clocks RAS-only before CAS on an access (>=1)
T_RAS_REF, 2, clocks RAS+CAS held low during refresh (>=1)
T_RP, 2, precharge clocks, all strobes high, after any cycle (>=1)

Ports:
CLK  in  1  system clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
cpu_req  in  1  level request from decoder; held until CPU cycle ends
cpu_rwn  in  1  1=read, 0=write; stable while cpu_req high
cpu_ube  in  1  upper byte enable
cpu_lbe  in  1  lower byte enable
cpu_ack  out  1  1 while CAS is asserted for the CPU (data valid / written)
RASn  out  1  DRAM RAS, active low
UCASn  out  1  upper CAS, active low
LCASn  out  1  lower CAS, active low
MEMWn  out  1  DRAM write enable, active low
row_sel  out  1  1=drive row address to MADDR mux, 0=column
refresh_busy  out  1  1 in REF_CAS/REF_RAS
pending_count  out  clog2(MAX_PENDING+1)  queued refreshes
refresh_overrun  out  1  sticky: tick arrived with queue full

Behaviour:
- All outputs registered. On RESET: state=IDLE, RASn/UCASn/LCASn/MEMWn=1, cpu_ack=0, row_sel=1, refresh_busy=0, pending_count=0, refresh_overrun=0, timer=REFRESH_INTERVAL-1. RESET mid-cycle forces this on the next edge. No completion of the open access or refresh.
- Timer: decrements each clock. At 0 it reloads REFRESH_INTERVAL-1 and issues a tick. The first tick occurs on the 110th edge after RESET deasserts.
- Tick: pending_count+1. If already MAX_PENDING, saturate and set refresh_overrun (cleared only by RESET).
- Entering REF_CAS: pending_count-1. A tick on the same edge leaves pending_count unchanged.
- States: IDLE, ACC_RAS, ACC_CAS, REF_CAS, REF_RAS, PRECHARGE.
- IDLE arbitration, evaluated each edge, in priority order:
  - pending_count==MAX_PENDING -> REF_CAS.
  - else cpu_req -> ACC_RAS.
  - else pending_count>0 -> REF_CAS.
  - else stay IDLE.
- ACC_RAS: RASn=0, row_sel=1, all CAS high. Lasts T_RCD clocks, then ACC_CAS.
- ACC_CAS outputs:
  - RASn=0, row_sel=0, cpu_ack=1.
  - UCASn=~cpu_ube, LCASn=~cpu_lbe.
  - MEMWn=cpu_rwn.
- ACC_CAS exit: stays while cpu_req=1. cpu_req=0 -> PRECHARGE with all strobes high, MEMWn=1, cpu_ack=0 on that edge.
- cpu_req dropping during ACC_RAS -> PRECHARGE. cpu_ack never asserts for that request.
- REF_CAS (1 clock): UCASn=LCASn=0, RASn=1, MEMWn=1, refresh_busy=1.
- REF_RAS (T_RAS_REF clocks): RASn=UCASn=LCASn=0, MEMWn=1, refresh_busy=1. Then PRECHARGE.
- PRECHARGE: T_RP clocks all high, row_sel=1, then IDLE.
- Latency: cpu_req sampled high in IDLE at edge n -> RASn low after edge n+1 -> cpu_ack and CAS after edge n+1+T_RCD.
- Refresh cannot interrupt an access in progress; it waits for the next IDLE. A CPU held off by refresh keeps cpu_req high and is served at the next IDLE.
- Phase counter width clog2(max(T_RCD,T_RAS_REF,T_RP)+1). It wraps only by reload on state entry.

Test Plan:
- Reset, no requests -> after 110 clocks pending_count=1, REF_CAS next edge (UCASn=LCASn=0 1 clk), REF_RAS RASn=UCASn=LCASn=0 2 clks, precharge 2 clks, pending_count=0, MEMWn stays 1.
- Word read: cpu_req=1, ube=lbe=1, rwn=1 at edge n -> RASn=0 after n+1; after n+2 UCASn=LCASn=0, cpu_ack=1, MEMWn=1, row_sel=0; drop req -> all high next edge, 2 precharge clocks, then IDLE.
- Byte write: lbe=1, ube=0, rwn=0 -> LCASn=0, UCASn=1, MEMWn=0 during ACC_CAS; MEMWn=1 after req drops.
- Tick coinciding with REF_CAS entry (pending=1) -> pending_count stays 1. Tick coinciding with pending=0 and CPU start -> pending=1, access served first, refresh follows the precharge.
- Priority: hold cpu_req high in ACC_CAS for 4x110 clocks -> pending_count=4; release and immediately re-request -> REF_CAS chosen over CPU; CPU served after 1+2+2 refresh/precharge clocks.
- Overrun/reset: hold access 5x110 clocks -> pending_count saturates at 4, refresh_overrun=1; assert RESET during ACC_CAS -> next edge all strobes high, cpu_ack=0, pending_count=0, refresh_overrun=0.
